// File: rtl/pixel_row_readout.sv
// pixel_row_readout
//
// Digital back-end for one pixel row. While convert is high it latches, for
// each pixel, the shared ramp code on the first cycle that pixel's comparator
// reports a crossing. When conversion ends, any pixel that never tripped is
// marked as overflowed and gets an all-ones code. A read_start pulse in HOLD
// then streams the row out, one pixel per valid/ready beat, while driving the
// row decoder select.
//
// Optional build macro:
//   PIXEL_READOUT_CDS_EN - correlated double sampling. Two conversions per row:
//                          the first captures reset levels and the second
//                          captures signal levels. Each beat carries
//                          signal - reset, clamped at 0, and out_ovf is set if
//                          either sample overflowed.
//
// Ports:
//   clk, reset   system clock (posedge) and asynchronous active-high reset
//   convert      level, high for the whole conversion phase
//   ramp_code    shared digital ramp value
//   cmp          per-pixel comparator, 1 = ramp has crossed the pixel level
//   read_start   single-cycle readout request, honoured only in HOLD
//   sel          decoder select, index of the pixel being read
//   out_data     pixel code (or CDS difference)
//   out_addr     pixel index of out_data
//   out_ovf      pixel never tripped during conversion
//   out_valid    out_data/out_addr/out_ovf valid
//   out_ready    consumer accepts the current beat
//   busy         high while in CAPTURE or READ
//   done         one-cycle pulse after the last beat is accepted
//
// Handshake: a beat transfers on a posedge where out_valid and out_ready are
// both high. Once raised, out_valid stays high and out_* stay constant until
// that beat transfers; it only drops after the last pixel's beat.
//
// The FSM state is held in state_q (type state_t) so checkers can bind to it.

module pixel_row_readout #(
    parameter int DECODER_WIDTH = 2,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          convert,
    input  logic [DATA_WIDTH-1:0]         ramp_code,
    input  logic [(2**DECODER_WIDTH)-1:0] cmp,
    input  logic                          read_start,
    output logic [DECODER_WIDTH-1:0]      sel,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [DECODER_WIDTH-1:0]      out_addr,
    output logic                          out_ovf,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          done
);

    localparam int N = 2**DECODER_WIDTH;
    localparam logic [DECODER_WIDTH-1:0] LAST_SEL = DECODER_WIDTH'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLD    = 2'd2,
        ST_READ    = 2'd3
    } state_t;

    state_t                            state_q, state_d;
    logic [N-1:0][DATA_WIDTH-1:0]      code_q, code_d;
    logic [N-1:0]                      latched_q, latched_d;
    logic [DECODER_WIDTH-1:0]          sel_q, sel_d;
    logic                              out_valid_q, out_valid_d;
    logic                              done_q, done_d;
    logic                              start_conv;
    logic                              read_ok;
    logic [DATA_WIDTH-1:0]             pix_data;
    logic                              pix_ovf;

`ifdef PIXEL_READOUT_CDS_EN
    logic [N-1:0][DATA_WIDTH-1:0]      rst_code_q, rst_code_d;
    logic [N-1:0]                      rst_ovf_q, rst_ovf_d;
    logic                              second_q, second_d;   // next/last conversion is the signal pass
    logic [DATA_WIDTH-1:0]             sig_code, ref_code;

    // Readout only makes sense once both samples of the row exist.
    assign read_ok  = second_q;
    assign sig_code = code_q[sel_q];
    assign ref_code = rst_code_q[sel_q];
    assign pix_data = (sig_code >= ref_code) ? (sig_code - ref_code) : '0;
    assign pix_ovf  = ~latched_q[sel_q] | rst_ovf_q[sel_q];
`else
    assign read_ok  = 1'b1;
    assign pix_data = code_q[sel_q];
    assign pix_ovf  = ~latched_q[sel_q];
`endif

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        latched_d   = latched_q;
        sel_d       = sel_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        start_conv  = 1'b0;
`ifdef PIXEL_READOUT_CDS_EN
        rst_code_d  = rst_code_q;
        rst_ovf_d   = rst_ovf_q;
        second_d    = second_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (convert) begin
                    start_conv = 1'b1;
`ifdef PIXEL_READOUT_CDS_EN
                    second_d   = 1'b0;
`endif
                end
            end

            ST_CAPTURE: begin
                if (convert) begin
                    for (int i = 0; i < N; i++) begin
                        if (cmp[i] && !latched_q[i]) begin
                            code_d[i]    = ramp_code;
                            latched_d[i] = 1'b1;
                        end
                    end
                end else begin
                    // Pixels that never tripped saturate; their overflow is
                    // implied by latched staying 0.
                    for (int i = 0; i < N; i++) begin
                        if (!latched_q[i]) begin
                            code_d[i] = '1;
                        end
                    end
                    state_d = ST_HOLD;
                end
            end

            ST_HOLD: begin
                // A new conversion takes priority over reading the old row.
                if (convert) begin
                    start_conv = 1'b1;
`ifdef PIXEL_READOUT_CDS_EN
                    if (!second_q) begin
                        rst_code_d = code_q;
                        rst_ovf_d  = ~latched_q;
                        second_d   = 1'b1;
                    end else begin
                        second_d   = 1'b0;
                    end
`endif
                end else if (read_start && read_ok) begin
                    sel_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = ST_READ;
                end
            end

            ST_READ: begin
                if (out_valid_q && out_ready) begin
                    if (sel_q == LAST_SEL) begin
                        sel_d       = '0;
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        sel_d = sel_q + DECODER_WIDTH'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Entering CAPTURE: flags restart from cleared, and this edge already
        // counts as the first capture sample.
        if (start_conv) begin
            state_d = ST_CAPTURE;
            for (int i = 0; i < N; i++) begin
                latched_d[i] = cmp[i];
                if (cmp[i]) begin
                    code_d[i] = ramp_code;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            code_q      <= '0;
            latched_q   <= '0;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef PIXEL_READOUT_CDS_EN
            rst_code_q  <= '0;
            rst_ovf_q   <= '0;
            second_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            latched_q   <= latched_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
`ifdef PIXEL_READOUT_CDS_EN
            rst_code_q  <= rst_code_d;
            rst_ovf_q   <= rst_ovf_d;
            second_q    <= second_d;
`endif
        end
    end

    // Payload is forced to zero whenever no beat is being offered.
    assign sel       = sel_q;
    assign out_addr  = sel_q;
    assign out_data  = out_valid_q ? pix_data : '0;
    assign out_ovf   = out_valid_q & pix_ovf;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == ST_CAPTURE) || (state_q == ST_READ);
    assign done      = done_q;

endmodule

// File: doc/pixel_row_readout.md
# pixel_row_readout

Digital readout back-end for one pixel row: the receiving end of the ERASE/EXPOSE/CONVERT/READ sequence driven by the row controller. During CONVERT it watches per-pixel comparator outputs against the shared digital ramp code and latches each pixel's code when its comparator trips. During READ it drives the row decoder select and streams the latched codes out one pixel per transfer over a valid/ready handshake.

## Interface
- DECODER_WIDTH, 2, decoder select width; row holds N = 2**DECODER_WIDTH pixels
- DATA_WIDTH, 8, ramp code and pixel code width
- clk  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-high
- convert  in  1  level, high for the whole CONVERT phase
- ramp_code  in  DATA_WIDTH  digital ramp value, increments each cycle while convert is high
- cmp  in  N  per-pixel comparator; 1 = ramp has crossed pixel voltage
- read_start  in  1  single-cycle pulse requesting row readout
- sel  out  DECODER_WIDTH  decoder_in drive, index of pixel being read
- out_data  out  DATA_WIDTH  pixel code
- out_addr  out  DECODER_WIDTH  pixel index of out_data
- out_ovf  out  1  pixel never tripped during conversion
- out_valid  out  1  out_data/out_addr/out_ovf valid
- out_ready  in  1  consumer accepts beat
- busy  out  1  high in CAPTURE or READ
- done  out  1  one-cycle pulse after last beat accepted

## Operation
- States: IDLE, CAPTURE, HOLD, READ.
- IDLE: convert sampled 1 -> clear all latched flags, go CAPTURE; this same edge is the first capture sample.
- CAPTURE: each posedge, for every pixel i with cmp[i]=1 and not yet latched: code[i] <= ramp_code, latched[i] <= 1. Pixels tripping on the same edge all latch the same code. Comparator glitching back to 0 after latch is ignored.
- CAPTURE, convert sampled 0 -> every unlatched pixel gets code = all-ones, ovf = 1; go HOLD.
- HOLD: read_start -> sel = 0, go READ. convert rising in HOLD -> discard row, restart CAPTURE (new conversion wins).
- read_start outside HOLD is ignored (no queuing).
- READ: present pixel sel on out_*; beat transfers on posedge with out_valid & out_ready. On transfer of pixel k < N-1: sel/out_addr <= k+1, out_valid stays high. On transfer of pixel N-1: out_valid <= 0, done pulse, go IDLE.
- out_valid never drops without a transfer; out_* stable while out_valid & !out_ready.
- convert asserted during READ is ignored; readout completes first.
- Reset mid-operation: all state, codes and flags cleared immediately; back to IDLE.

## Timing
- Reset values: sel 0, out_data 0, out_addr 0, out_ovf 0, out_valid 0, busy 0, done 0.
- Capture latency: cmp high at posedge t -> code = ramp_code sampled at t.
- read_start sampled at t -> out_valid high after t+1, first beat address 0.
- With out_ready held 1: N beats on N consecutive cycles; done high the cycle after the last beat.
- busy high from the cycle after CAPTURE entry until READ exit; low in IDLE and HOLD.
- ramp_code wraps are not detected; the controller guarantees at most 2**DATA_WIDTH convert cycles.

## Configuration
- PIXEL_READOUT_CDS_EN defined: correlated double sampling. Each readout needs two conversions: the first convert phase captures reset levels, the second captures signal levels. out_data = signal − reset, clamped to 0 when negative. out_ovf = 1 if either sample overflowed. read_start is honoured only in HOLD after the second conversion; after the first, HOLD waits for convert.
- Not defined: single conversion; out_data = raw latched code.

## Test plan
- N=4, ramp 0..19, cmp[i] rises at ramp = 3, 7, 7, 12; read_start with out_ready=1 -> beats (0,3),(1,7),(2,7),(3,12), out_ovf 0, done one cycle after the 4th beat.
- cmp[3] never rises over a 20-cycle convert -> beat 3 is 0xFF with out_ovf=1; other pixels unaffected.
- out_ready toggles 1,0,0,1,… -> out_data/out_addr stay stable while stalled; no beat lost or duplicated; sel tracks out_addr.
- read_start pulsed during CAPTURE and in IDLE -> no out_valid; a later read_start in HOLD yields a normal readout.
- reset asserted at beat 2 of READ -> out_valid 0 and sel 0 immediately; the next conversion captures fresh codes.
- CDS_EN: reset pass trips at 2, 2, 5, 9; signal pass trips at 10, 1, 5, 30 -> beats 8, 0, 0, 21.
